// File: rtl/iq_frame_scheduler_if.sv
// Bus bundle between the IQ frame scheduler and its sample source / byte reader.
// The master drives samples and read strobes; the slave is the scheduler.
interface iq_frame_scheduler_if;
  logic signed [31:0] RX1_I;
  logic signed [31:0] RX1_Q;
  logic signed [31:0] RX2_I;
  logic signed [31:0] RX2_Q;
  logic               iq_valid;
  logic               rx1_en;
  logic               rx2_en;
  logic               rd_start;
  logic               byte_rd;
  logic               clear_flags;
  logic [7:0]         byte_out;
  logic               byte_valid;
  logic               frame_done;
  logic [2:0]         fifo_level;
  logic               overflow;
  logic               underrun;
  logic [1:0]         state_dbg;

  // Handshake: byte_valid=1 means byte_out is stable and held until the
  // reader pulses byte_rd for one cycle; the next byte appears one cycle later.
  modport master (
    output RX1_I, RX1_Q, RX2_I, RX2_Q, iq_valid, rx1_en, rx2_en,
           rd_start, byte_rd, clear_flags,
    input  byte_out, byte_valid, frame_done, fifo_level, overflow, underrun,
           state_dbg
  );

  modport slave (
    input  RX1_I, RX1_Q, RX2_I, RX2_Q, iq_valid, rx1_en, rx2_en,
           rd_start, byte_rd, clear_flags,
    output byte_out, byte_valid, frame_done, fifo_level, overflow, underrun,
           state_dbg
  );
endinterface

// File: rtl/iq_frame_scheduler.sv
// Buffers up to four 128-bit IQ frames and serialises the head frame as bytes,
// MSB first, skipping the 8 bytes of any receiver disabled at frame start.
module iq_frame_scheduler (
  input  logic           clk_in,
  input  logic           reset,
  iq_frame_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2} state_t;

  state_t       state;
  logic [127:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic [2:0]   count;
  logic [127:0] frame_reg;
  logic         en1;
  logic         en2;
  logic [3:0]   idx;
  logic [3:0]   last_idx;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         frame_done;
  logic         overflow;
  logic         underrun;

  logic         full;
  logic         pop;
  logic         push_ok;
  logic         ovf_ev;
  logic         und_ev;
  logic [127:0] frame_in;

  always_comb begin
    full     = (count == 3'd4);
    pop      = bus.rd_start && (count != 3'd0);
    push_ok  = bus.iq_valid && (!full || pop);
    ovf_ev   = bus.iq_valid && full && !pop;
    und_ev   = bus.rd_start && (count == 3'd0);
    frame_in = {bus.RX1_Q, bus.RX1_I, bus.RX2_Q, bus.RX2_I};
  end

  // Byte k of a frame, k=0 being the top byte of RX1_Q.
  function automatic logic [7:0] pick(input logic [127:0] f, input logic [3:0] k);
    logic [127:0] sh;
    sh = f << {k, 3'b000};
    return sh[127:120];
  endfunction

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= frame_in;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // A new error event in the same cycle as clear_flags keeps its flag set.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overflow <= ovf_ev || (overflow && !bus.clear_flags);
      underrun <= und_ev || (underrun && !bus.clear_flags);
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frame_reg  <= '0;
      en1        <= 1'b0;
      en2        <= 1'b0;
      idx        <= 4'd0;
      last_idx   <= 4'd0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bus.rd_start) begin
        // Restart from any state; an abandoned frame gets no frame_done.
        en1        <= bus.rx1_en;
        en2        <= bus.rx2_en;
        if (pop) frame_reg <= mem[rd_ptr];
        byte_valid <= 1'b0;
        state      <= LOAD;
      end else begin
        case (state)
          LOAD: begin
            if (!en1 && !en2) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              idx        <= en1 ? 4'd0 : 4'd8;
              last_idx   <= en2 ? 4'd15 : 4'd7;
              byte_out   <= pick(frame_reg, en1 ? 4'd0 : 4'd8);
              byte_valid <= 1'b1;
              state      <= SEND;
            end
          end
          SEND: begin
            if (bus.byte_rd) begin
              if (idx == last_idx) begin
                byte_valid <= 1'b0;
                frame_done <= 1'b1;
                state      <= IDLE;
              end else begin
                idx      <= idx + 4'd1;
                byte_out <= pick(frame_reg, idx + 4'd1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.byte_out   = byte_out;
  assign bus.byte_valid = byte_valid;
  assign bus.frame_done = frame_done;
  assign bus.fifo_level = count;
  assign bus.overflow   = overflow;
  assign bus.underrun   = underrun;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_iq_frame_scheduler.sv
// Bench for iq_frame_scheduler: directed scenarios plus random traffic, all
// checked each cycle against a queue-based model of frames and bytes.
module tb_iq_frame_scheduler;
  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  iq_frame_scheduler_if bus();

  iq_frame_scheduler dut (.clk_in(clk_in), .reset(reset), .bus(bus));

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Model: stored frames, frame being sent, bytes still to deliver.
  logic [127:0] fifo_m[$];
  logic [127:0] frame_m;
  logic [7:0]   exp_q[$];
  bit           ovf_m, und_m, load_pend, bv_exp, fd_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    fifo_m.delete();
    exp_q.delete();
    frame_m = '0;
    ovf_m = 0; und_m = 0; load_pend = 0; bv_exp = 0; fd_exp = 0;
  endtask

  task automatic set_frame(input logic [31:0] q1, i1, q2, i2);
    bus.RX1_Q = q1; bus.RX1_I = i1; bus.RX2_Q = q2; bus.RX2_I = i2;
  endtask

  task automatic rand_frame();
    set_frame($urandom, $urandom, $urandom, $urandom);
  endtask

  // One clock: drive strobes, advance the model, then check every output.
  task automatic tick(input bit iqv, input bit rds, input bit brd, input bit clr);
    logic [127:0] f;
    bit ovf_ev, und_ev;
    ovf_ev = 0; und_ev = 0;
    bus.iq_valid = iqv; bus.rd_start = rds; bus.byte_rd = brd; bus.clear_flags = clr;
    f = {bus.RX1_Q, bus.RX1_I, bus.RX2_Q, bus.RX2_I};
    fd_exp = 0;
    if (rds) begin
      if (fifo_m.size() > 0) frame_m = fifo_m.pop_front();
      else und_ev = 1;
      exp_q.delete();
      for (int k = 0; k < 16; k++)
        if ((k < 8 && bus.rx1_en) || (k >= 8 && bus.rx2_en))
          exp_q.push_back(frame_m[127 - 8*k -: 8]);
      load_pend = 1;
      bv_exp = 0;
    end else if (load_pend) begin
      load_pend = 0;
      if (exp_q.size() == 0) fd_exp = 1;
      else bv_exp = 1;
    end else if (bv_exp && brd) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        bv_exp = 0;
        fd_exp = 1;
      end
    end
    if (iqv) begin
      if (fifo_m.size() < 4) fifo_m.push_back(f);
      else ovf_ev = 1;
    end
    if (clr) begin ovf_m = 0; und_m = 0; end
    if (ovf_ev) ovf_m = 1;
    if (und_ev) und_m = 1;
    @(posedge clk_in); #1;
    bus.iq_valid = 0; bus.rd_start = 0; bus.byte_rd = 0; bus.clear_flags = 0;
    check("fifo_level", 32'(bus.fifo_level), 32'(fifo_m.size()));
    check("overflow", 32'(bus.overflow), 32'(ovf_m));
    check("underrun", 32'(bus.underrun), 32'(und_m));
    check("byte_valid", 32'(bus.byte_valid), 32'(bv_exp));
    check("frame_done", 32'(bus.frame_done), 32'(fd_exp));
    if (bv_exp) check("byte_out", 32'(bus.byte_out), 32'(exp_q[0]));
  endtask

  task automatic set_en(input bit e1, input bit e2);
    bus.rx1_en = e1; bus.rx2_en = e2;
  endtask

  // rd_start, LOAD cycle, then consume every byte with occasional stalls.
  task automatic read_frame();
    int guard;
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      if ($urandom_range(0, 3) == 0) tick(0, 0, 0, 0);
      else tick(0, 0, 1, 0);
      guard++;
    end
    check("read_budget", 32'(exp_q.size()), 32'd0);
    tick(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    check("rst_byte_out", 32'(bus.byte_out), 32'd0);
    check("rst_flags", 32'({bus.overflow, bus.underrun}), 32'd0);
    @(posedge clk_in); #1;
    check("rst_no_done", 32'(bus.frame_done), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.iq_valid = 0; bus.rd_start = 0; bus.byte_rd = 0; bus.clear_flags = 0;
    set_en(1, 1);
    set_frame(0, 0, 0, 0);
    model_clear();
    @(posedge clk_in); #1;
    do_reset();

    // Single frame, both receivers.
    set_frame(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00);
    tick(1, 0, 0, 0);
    check("one_push_level", 32'(bus.fifo_level), 32'd1);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    check("first_byte_both", 32'(bus.byte_out), 32'h11);
    for (int k = 0; k < 16; k++) begin
      if (k == 4) begin tick(0, 0, 0, 0); tick(0, 0, 0, 0); end
      tick(0, 0, 1, 0);
    end
    check("after_both_level", 32'(bus.fifo_level), 32'd0);

    // RX2 only.
    tick(1, 0, 0, 0);
    set_en(0, 1);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    check("first_byte_rx2", 32'(bus.byte_out), 32'h99);
    for (int k = 0; k < 8; k++) tick(0, 0, 1, 0);

    // No receivers: frame_done straight from LOAD.
    set_en(0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);

    // Five pushes, fifth dropped.
    set_en(1, 1);
    for (int k = 0; k < 5; k++) begin rand_frame(); tick(1, 0, 0, 0); end
    check("full_level", 32'(bus.fifo_level), 32'd4);
    check("full_overflow", 32'(bus.overflow), 32'd1);
    tick(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) read_frame();

    // Full FIFO with simultaneous push and pop.
    for (int k = 0; k < 4; k++) begin rand_frame(); tick(1, 0, 0, 0); end
    rand_frame();
    tick(1, 1, 0, 0);
    check("pushpop_level", 32'(bus.fifo_level), 32'd4);
    check("pushpop_overflow", 32'(bus.overflow), 32'd0);
    tick(0, 0, 0, 0);
    while (exp_q.size() > 0) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) read_frame();

    // Empty FIFO: underrun and repeat of the last frame.
    read_frame();
    check("underrun_set", 32'(bus.underrun), 32'd1);
    tick(0, 0, 0, 1);
    check("underrun_cleared", 32'(bus.underrun), 32'd0);

    // Restart mid-frame abandons it without frame_done.
    for (int k = 0; k < 2; k++) begin rand_frame(); tick(1, 0, 0, 0); end
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 0, 1, 0);
    read_frame();

    // Reset after the fifth byte.
    rand_frame();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(0, 0, 1, 0);
    do_reset();
    tick(0, 0, 0, 0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      rand_frame();
      set_en($urandom_range(0, 1), $urandom_range(0, 1));
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 23) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iq_frame_scheduler.md
IQ_FRAME_SCHEDULER -- requirements
Module: iq_frame_scheduler

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports RX1_I, RX1_Q, RX2_I, RX2_Q, input, 32 bits each, signed: decimated IQ samples.
REQ-004 SHALL have port iq_valid, input, 1 bit: one-cycle strobe; the RX samples are valid in that cycle.
REQ-005 SHALL have ports rx1_en and rx2_en, input, 1 bit each: receiver enables, sampled at frame start.
REQ-006 SHALL have port rd_start, input, 1 bit: one-cycle strobe from the bus interface when an RX IQ command begins.
REQ-007 SHALL have port byte_rd, input, 1 bit: one-cycle strobe; the bus has consumed the current byte.
REQ-008 SHALL have port clear_flags, input, 1 bit: one-cycle strobe that clears the sticky flags.
REQ-009 SHALL have port byte_out, output, 8 bits: the current byte.
REQ-010 SHALL have port byte_valid, output, 1 bit: byte_out holds a valid byte.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-012 SHALL have port fifo_level, output, 3 bits: stored frames, range 0..4.
REQ-013 SHALL have ports overflow and underrun, output, 1 bit each: sticky error flags.

Function
REQ-014 SHALL store frames in a 4-deep FIFO; one frame is {RX1_Q, RX1_I, RX2_Q, RX2_I} (128 bits), captured on iq_valid.
REQ-015 SHALL drop the incoming frame when iq_valid arrives with the FIFO full and no pop in that cycle; the FIFO SHALL remain unchanged and overflow SHALL be set.
REQ-016 SHALL treat a push and a pop in the same cycle as both accepted, fifo_level unchanged; with the FIFO full this SHALL NOT set overflow.
REQ-017 SHALL use the read FSM states IDLE, LOAD and SEND.
REQ-018 SHALL, on rd_start in IDLE, latch rx1_en and rx2_en, pop the FIFO head into a 128-bit frame register if fifo_level>0, and go to LOAD.
REQ-019 SHALL, on rd_start with fifo_level=0, leave the frame register holding the last frame sent (all zeros after reset) and set underrun.
REQ-020 SHALL, in LOAD, set the byte count N = 8 × (number of latched enables) and go to SEND with byte_valid=1 on the next cycle; byte_out SHALL be valid 2 cycles after rd_start.
REQ-021 SHALL, when N=0, pulse frame_done in the LOAD→IDLE cycle and never assert byte_valid.
REQ-022 SHALL send bytes MSB-first in the order RX1_Q[31:24]..RX1_Q[7:0], RX1_I[31:24]..RX1_I[7:0], then RX2_Q and RX2_I; a disabled receiver's 8 bytes SHALL be skipped.
REQ-023 SHALL, in SEND, advance byte_out on each byte_rd, taking effect the next cycle; with no byte_rd it SHALL hold the byte indefinitely.
REQ-024 SHALL, on byte_rd of the last byte, deassert byte_valid, pulse frame_done for 1 cycle and return to IDLE.
REQ-025 SHALL, on rd_start in LOAD or SEND, abandon the current frame without frame_done and restart per REQ-018.
REQ-026 SHALL ignore byte_rd in IDLE and LOAD.
REQ-027 SHALL clear both sticky flags on clear_flags; an error event in the same cycle SHALL win and leave its flag set.

Reset
REQ-028 SHALL, while reset=1, asynchronously force: FIFO empty, fifo_level=0, FSM=IDLE, frame register=0, byte_out=0, byte_valid=0, frame_done=0, overflow=0, underrun=0.
REQ-029 SHALL, on reset asserted mid-frame, discard the frame without a frame_done pulse.

Verification
REQ-030 Bench SHALL cover: 1 push with RX1_Q=0x11223344, RX1_I=0x55667788, RX2_Q=0x99AABBCC, RX2_I=0xDDEEFF00, both receivers enabled, rd_start, then 16 byte_rd -> bytes 11,22,...,FF,00 in order, frame_done after the 16th, fifo_level 1→0.
REQ-031 Bench SHALL cover: rx1_en=0, rx2_en=1, same frame -> 8 bytes 99..00, then frame_done.
REQ-032 Bench SHALL cover: 5 pushes with no pops -> fifo_level=4, overflow=1, and the 5th frame absent on readout.
REQ-033 Bench SHALL cover: FIFO full with iq_valid and rd_start in the same cycle -> level stays 4, overflow=0.
REQ-034 Bench SHALL cover: rd_start with the FIFO empty -> underrun=1 and the previous frame repeated; clear_flags -> underrun=0.
REQ-035 Bench SHALL cover: reset after the 5th byte -> byte_valid=0 immediately, no frame_done, fifo_level=0.
